preemph: RTL and testbench
==========================

Name: preemph

Overview:
- First-order fixed-point pre-emphasis filter for the transmit/test-source side of the FM chain. It is the inverse-direction counterpart of the receive-side de-emphasis stage.
- Pops signed samples from an upstream FIFO, computes y[n] = (B0*x[n] + B1*x[n-1] + A1*y[n-1]) >>> FRAC_BITS with saturation, and pushes y[n] to a downstream FIFO.
- Sits between two standard `fifo` instances in a top wrapper.
- Both FIFOs are first-word-fall-through:
  - in_dout is valid whenever in_empty=0.
  - in_rd_en pops the entry at the next clock edge.

Parameters:
DATA_WIDTH, 32, sample width; two's complement in and out
FRAC_BITS, 10, fractional bits of the coefficients (Q-format scale 2^FRAC_BITS)
B0, 2943, signed coefficient on x[n] (about 2.874 in Q10)
B1, -1919, signed coefficient on x[n-1] (about -1.874 in Q10)
A1, 0, signed feedback coefficient on y[n-1]; all coefficients satisfy abs(coef) < 2^15

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_dout  input  DATA_WIDTH  head of input FIFO, signed sample x[n]
in_empty  input  1  input FIFO empty
in_rd_en  output  1  pop input FIFO
out_din  output  DATA_WIDTH  filtered sample y[n]
out_full  input  1  output FIFO full
out_wr_en  output  1  push out_din into output FIFO

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values:
  - state=S_READ; x_prev=0, y_prev=0, acc=0.
  - out_din=0 (registered); in_rd_en=0 and out_wr_en=0 (combinational from state).
  - While reset=1 nothing is popped or pushed.
- FSM:
  - S_READ: in_rd_en = !in_empty. If !in_empty: x_cur <= in_dout; go to S_CALC. Otherwise stay.
  - S_CALC: acc <= B0*x_cur + B1*x_prev + A1*y_prev; go to S_WRITE.
    - Signed arithmetic throughout; acc is 2*DATA_WIDTH+2 bits, so it cannot overflow.
    - Shift and saturate: y = acc >>> FRAC_BITS (arithmetic shift, i.e. floor, no rounding), clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - out_din <= y at the end of S_CALC.
  - S_WRITE: out_wr_en = !out_full. If !out_full: x_prev <= x_cur; y_prev <= out_din (the saturated value); go to S_READ. Otherwise stay; out_din holds stable.
- Latency and throughput:
  - Pop at edge t gives out_wr_en high in cycle t+2 if out_full=0.
  - Peak throughput is 1 sample per 3 cycles.
- Handshake rules:
  - in_rd_en is asserted only in S_READ with in_empty=0.
  - out_wr_en is asserted only in S_WRITE with out_full=0.
  - Each is a single-cycle pulse per sample; never both in the same cycle.
- Backpressure:
  - out_full high stalls in S_WRITE indefinitely.
  - No further pops while stalled; history is not updated until the write completes.
- Starvation: in_empty high idles in S_READ; state, history and out_din are held.
- Reset mid-operation:
  - A sample already popped but not yet written is discarded.
  - History is cleared; the next sample is filtered as if it were the first.
- Simultaneous events: out_full deasserting in the same cycle in_empty deasserts → write this cycle, pop next cycle (S_READ).

Test Plan:
- Reset with in_empty=0 and in_dout=1234 held for 3 cycles → in_rd_en=0, out_wr_en=0, out_din=0 throughout; first pop occurs in the cycle after reset drops.
- Step: feed 1024 ×4, out_full=0 → outputs 2943, 1024, 1024, 1024; out_wr_en exactly 2 cycles after each pop; pops spaced 3 cycles apart.
- Floor rounding: feed -1, 0, 0 → outputs -3 (floor of -2943/1024), 1 (1919>>10), 0.
- Saturation: feed 0x7FFFFFFF, 0x80000000, 0 → outputs 0x7FFFFFFF, 0x80000000 (B0*min + B1*max underflows), then 0x7FFFFFFF (-1919*-2^31 >>10 exceeds max).
- Feedback override (B0=1024, B1=0, A1=512): impulse 1024 then 0 ×3 → outputs 1024, 512, 256, 128.
- Backpressure/reset:
  - Hold out_full=1 for 5 cycles in S_WRITE → out_wr_en=0, in_rd_en=0, out_din stable; release → exactly one write, then a pop.
  - Assert reset during S_CALC → that sample is never written; next input 1024 yields 2943.

Source files
------------

// File: rtl/preemph.sv
// preemph: first-order fixed-point pre-emphasis filter between two FWFT FIFOs.
// y[n] = sat((B0*x[n] + B1*x[n-1] + A1*y[n-1]) >>> FRAC_BITS), one sample per three cycles.
module preemph #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int          B0         = 2943,
    parameter int          B1         = -1919,
    parameter int          A1         = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    // Accumulator is wide enough that three products of |coef| < 2^15 never wrap.
    localparam int unsigned ACC_W = 2 * DATA_WIDTH + 2;

    localparam logic signed [ACC_W-1:0] B0_W = ACC_W'(B0);
    localparam logic signed [ACC_W-1:0] B1_W = ACC_W'(B1);
    localparam logic signed [ACC_W-1:0] A1_W = ACC_W'(A1);

    // Representable output range, expressed at accumulator width for comparison.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic signed [DATA_WIDTH-1:0] x_cur_q,   x_cur_d;
    logic signed [DATA_WIDTH-1:0] x_prev_q,  x_prev_d;
    logic signed [DATA_WIDTH-1:0] y_prev_q,  y_prev_d;
    logic signed [DATA_WIDTH-1:0] out_din_q, out_din_d;

    logic signed [ACC_W-1:0]      acc_c;
    logic signed [ACC_W-1:0]      shifted_c;
    logic signed [DATA_WIDTH-1:0] y_sat_c;

    // Filter datapath: multiply-accumulate, floor shift, clamp to output range.
    always_comb begin
        acc_c = B0_W * ACC_W'(x_cur_q)
              + B1_W * ACC_W'(x_prev_q)
              + A1_W * ACC_W'(y_prev_q);
        shifted_c = acc_c >>> FRAC_BITS;
        if (shifted_c > SAT_MAX) begin
            y_sat_c = DATA_WIDTH'(SAT_MAX);
        end else if (shifted_c < SAT_MIN) begin
            y_sat_c = DATA_WIDTH'(SAT_MIN);
        end else begin
            y_sat_c = DATA_WIDTH'(shifted_c);
        end
    end

    // Next-state, handshake strobes and register updates; reset masks both strobes.
    always_comb begin
        state_d   = state_q;
        x_cur_d   = x_cur_q;
        x_prev_d  = x_prev_q;
        y_prev_d  = y_prev_q;
        out_din_d = out_din_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;

        case (state_q)
            S_READ: begin
                in_rd_en = !in_empty;
                if (!in_empty) begin
                    x_cur_d = in_dout;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                out_din_d = y_sat_c;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                // History advances only once the sample is actually accepted downstream.
                out_wr_en = !out_full;
                if (!out_full) begin
                    x_prev_d = x_cur_q;
                    y_prev_d = out_din_q;
                    state_d  = S_READ;
                end
            end
            default: begin
                state_d = S_READ;
            end
        endcase

        if (reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_READ;
            x_cur_q   <= '0;
            x_prev_q  <= '0;
            y_prev_q  <= '0;
            out_din_q <= '0;
        end else begin
            state_q   <= state_d;
            x_cur_q   <= x_cur_d;
            x_prev_q  <= x_prev_d;
            y_prev_q  <= y_prev_d;
            out_din_q <= out_din_d;
        end
    end

    assign out_din = out_din_q;

endmodule

// File: tb/tb_preemph.sv
// tb_preemph: randomized and directed scoreboard bench for preemph.
// Two instances share all inputs: default coefficients and a feedback variant (B0=1024,B1=0,A1=512).
module tb_preemph;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] in_dout  = '0;
    logic        in_empty = 1'b1;
    logic        out_full = 1'b0;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] dout0, dout1;

    preemph u_dut (
        .clock    (clock),
        .reset    (reset),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .in_rd_en (rd0),
        .out_din  (dout0),
        .out_full (out_full),
        .out_wr_en(wr0)
    );

    preemph #(.B0(1024), .B1(0), .A1(512)) u_fb (
        .clock    (clock),
        .reset    (reset),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .in_rd_en (rd1),
        .out_din  (dout1),
        .out_full (out_full),
        .out_wr_en(wr1)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        longint y0;
        longint y1;
    } exp_t;

    int          errors   = 0;
    int          checks   = 0;
    longint      cyc      = 0;
    exp_t        exp_q[$];
    logic [31:0] src_q[$];
    int          gap_pct  = 0;
    int          full_pct = 0;
    longint      m_xp     = 0;
    longint      m_yp0    = 0;
    longint      m_yp1    = 0;
    bit          outstanding = 1'b0;
    longint      pop_cyc  = 0;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference filter: exact integer sum, floor division by 2^10, clamp to 32-bit range.
    function automatic longint filt(input longint b0, input longint b1, input longint a1,
                                    input longint x, input longint xp, input longint yp);
        longint s;
        longint q;
        s = b0 * x + b1 * xp + a1 * yp;
        q = s / 1024;
        if (s < 0 && (s % 1024) != 0) q = q - 1;
        if (q > MAXV) q = MAXV;
        if (q < MINV) q = MINV;
        return q;
    endfunction

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Upstream FIFO and downstream sink model; computes expected output at pop time.
    initial begin
        bit   do_pop;
        exp_t e;
        longint x;
        forever begin
            @(negedge clock);
            do_pop = rd0 && !in_empty && (src_q.size() > 0);
            if (do_pop) begin
                x    = sx(src_q[0]);
                e.y0 = filt(2943, -1919, 0, x, m_xp, m_yp0);
                e.y1 = filt(1024, 0, 512, x, m_xp, m_yp1);
                m_xp  = x;
                m_yp0 = e.y0;
                m_yp1 = e.y1;
                exp_q.push_back(e);
            end
            @(posedge clock);
            #1;
            if (do_pop) void'(src_q.pop_front());
            in_empty = (src_q.size() == 0) || ($urandom_range(99) < gap_pct);
            in_dout  = (src_q.size() != 0) ? src_q[0] : $urandom();
            out_full = ($urandom_range(99) < full_pct);
        end
    end

    // Monitor: handshake timing from an outstanding-sample view, data from the scoreboard.
    initial begin
        bit   exp_rd;
        bit   exp_wr;
        exp_t e;
        forever begin
            @(negedge clock);
            exp_rd = !outstanding && !in_empty && !reset;
            exp_wr = outstanding && (cyc >= pop_cyc + 2) && !out_full && !reset;
            check("rd_en", longint'(rd0), longint'(exp_rd));
            check("wr_en", longint'(wr0), longint'(exp_wr));
            check("fb_rd_en", longint'(rd1), longint'(exp_rd));
            check("fb_wr_en", longint'(wr1), longint'(exp_wr));
            if (wr0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("y", sx(dout0), e.y0);
                    check("fb_y", sx(dout1), e.y1);
                end
                outstanding = 1'b0;
            end
            if (reset) begin
                outstanding = 1'b0;
            end else if (rd0) begin
                outstanding = 1'b1;
                pop_cyc     = cyc;
            end
        end
    end

    task automatic feed(input longint v);
        src_q.push_back(32'(v));
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || outstanding) && n < limit) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: waited %0d cycles, limit %0d", n, limit);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        m_xp  = 0;
        m_yp0 = 0;
        m_yp1 = 0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Waits (bounded) until the instance is parked in the write state.
    task automatic wait_write_state(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!(outstanding && cyc >= pop_cyc + 2) && n < limit);
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL write_state_timeout: waited %0d cycles", n);
        end
    endtask

    task automatic wait_pop(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!outstanding && n < limit);
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL pop_timeout: waited %0d cycles", n);
        end
    endtask

    initial begin
        logic [31:0] held;

        // Reset held with data waiting: no strobes, output cleared.
        reset = 1'b1;
        feed(1234);
        repeat (3) begin
            @(negedge clock);
            check("rst_rd_en", longint'(rd0), 0);
            check("rst_wr_en", longint'(wr0), 0);
            check("rst_out_din", sx(dout0), 0);
            check("rst_fb_out_din", sx(dout1), 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_idle(100);

        // Step response from clean history.
        do_reset(2);
        repeat (4) feed(1024);
        wait_idle(200);

        // Impulse (feedback decay on the second instance), floor rounding, saturation.
        do_reset(2);
        feed(1024); feed(0); feed(0); feed(0);
        feed(-1); feed(0); feed(0);
        feed(32'h7FFF_FFFF); feed(sx(32'h8000_0000)); feed(0);
        wait_idle(400);

        // Backpressure: park in the write state, output must hold while full.
        full_pct = 100;
        feed(5000);
        feed(77);
        wait_write_state(50);
        held = dout0;
        repeat (5) begin
            @(negedge clock);
            #1;
            check("stall_out_din", sx(dout0), sx(held));
        end
        full_pct = 0;
        wait_idle(100);

        // Reset while the popped sample is being computed: it must never appear.
        feed(3000);
        wait_pop(50);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        m_xp  = 0;
        m_yp0 = 0;
        m_yp1 = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        feed(1024);
        wait_idle(100);

        // Randomized traffic with input gaps and output backpressure.
        gap_pct  = 30;
        full_pct = 30;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1) == 0) feed(longint'($urandom_range(4000)) - 2000);
            else                        feed(sx($urandom()));
        end
        wait_idle(6000);
        gap_pct  = 0;
        full_pct = 0;
        repeat (4) @(negedge clock);
        check("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
